// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared constants for the router packet FIFO slice.
//   DEF_DATA_W / DEF_DEPTH / DEF_AF_THRESH : default block parameters
//   LEN_LSB, len_msb()                     : header length-field position,
//                                            data[len_msb(DATA_W):LEN_LSB]
// -----------------------------------------------------------------------------
package router_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_AF_THRESH = 14;

  // Bits [1:0] of a header word are not part of the length field.
  localparam int LEN_LSB = 2;

  // The length field runs up to the top data bit.
  function automatic int len_msb(input int data_w);
    return data_w - 1;
  endfunction

endpackage

// File: rtl/router_pkt_len_tracker.sv
// -----------------------------------------------------------------------------
// router_pkt_len_tracker
// Follows packet framing on the read side of the FIFO. A header word loads the
// remaining-length counter with its length field + 1 (payload plus parity);
// each following body word counts it down, and the word that takes it from
// 1 to 0 is flagged as end of packet. Body words seen with nothing remaining
// are flagged as orphans.
// Ports:
//   clk, rst (async, active-high), soft_rst (sync flush)
//   rd_en    : a word is being read on this edge
//   rd_sop   : stored header tag of that word
//   rd_len   : length field of that word (only meaningful when rd_sop=1)
//   eop_out  : registered, aligned with the read word's data_valid
//   orphan   : registered one-cycle pulse, aligned with data_valid
// -----------------------------------------------------------------------------
module router_pkt_len_tracker
  import router_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       soft_rst,
  input  logic                       rd_en,
  input  logic                       rd_sop,
  input  logic [DATA_W-LEN_LSB-1:0]  rd_len,
  output logic                       eop_out,
  output logic                       orphan
);

  localparam int REM_W = DATA_W - 1;

  logic [REM_W-1:0] rem_reg;
  logic [REM_W-1:0] rem_next;
  logic             eop_reg;
  logic             eop_next;
  logic             orphan_reg;
  logic             orphan_next;
  logic [REM_W-1:0] hdr_rem;

  // Length field is one bit narrower than rem, so the +1 cannot overflow.
  assign hdr_rem = REM_W'(rd_len) + REM_W'(1);

  always_comb begin
    rem_next    = rem_reg;
    eop_next    = 1'b0;
    orphan_next = 1'b0;
    if (rd_en) begin
      if (rd_sop) begin
        // A new header always restarts framing; a truncated packet simply
        // never gets its eop.
        rem_next = hdr_rem;
      end else if (rem_reg != '0) begin
        rem_next = rem_reg - REM_W'(1);
        eop_next = (rem_reg == REM_W'(1));
      end else begin
        orphan_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_reg    <= '0;
      eop_reg    <= 1'b0;
      orphan_reg <= 1'b0;
    end else if (soft_rst) begin
      rem_reg    <= '0;
      eop_reg    <= 1'b0;
      orphan_reg <= 1'b0;
    end else begin
      rem_reg    <= rem_next;
      eop_reg    <= eop_next;
      orphan_reg <= orphan_next;
    end
  end

  assign eop_out = eop_reg;
  assign orphan  = orphan_reg;

endmodule

// File: rtl/router_pkt_fifo.sv
// -----------------------------------------------------------------------------
// router_pkt_fifo
// Packet-aware synchronous FIFO. Each entry holds {sop tag, data}. Reads are
// registered: a read accepted on an edge presents data_out/data_valid/sop_out
// (plus eop_out/orphan from the length tracker) right after that edge; cycles
// without an accepted read drive all of those outputs to 0.
// Optional build macro: ROUTER_PKT_FIFO_LEVEL_EN adds level/almost_full.
// Parameters: DATA_W (>=4), DEPTH (power of 2, >=4), AF_THRESH
// Ports:
//   clk, rst (async, active-high), soft_rst (sync flush, beats we/re)
//   we, sop, data_in       : write side
//   re                     : read request
//   data_out, data_valid   : registered read data and its qualifier
//   sop_out, eop_out       : header / last-word flags (qualified by data_valid)
//   orphan                 : body word read outside any packet
//   full, empty            : combinational status from the pointers
//   level, almost_full     : registered occupancy and threshold flag
//                            (only with ROUTER_PKT_FIFO_LEVEL_EN)
// -----------------------------------------------------------------------------
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEF_AF_THRESH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     soft_rst,
  input  logic                     we,
  input  logic                     sop,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     re,
  output logic [DATA_W-1:0]        data_out,
  output logic                     data_valid,
  output logic                     sop_out,
  output logic                     eop_out,
  output logic                     orphan,
  output logic                     full,
  output logic                     empty
`ifdef ROUTER_PKT_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full
`endif
);

  localparam int AW      = $clog2(DEPTH);
  localparam int PW      = AW + 1;
  localparam int LEN_MSB = len_msb(DATA_W);

  if (DATA_W < 4 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
      AF_THRESH < 0 || AF_THRESH > DEPTH) begin : g_bad_params
    $error("router_pkt_fifo: illegal parameter combination");
  end

  logic [DATA_W:0]   mem [DEPTH];
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W:0]   rd_word;
  logic [DATA_W-1:0] data_out_reg;
  logic              data_valid_reg;
  logic              sop_out_reg;

  // Pointers carry one extra wrap bit so all DEPTH entries are usable:
  // same index with differing wrap bits means full, identical means empty.
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);

  // Status is taken from the pre-edge state, so a simultaneous we/re at full
  // only reads and at empty only writes. A flush blocks both.
  assign wr_en = we & ~full  & ~soft_rst;
  assign rd_en = re & ~empty & ~soft_rst;

  // The word under the read pointer is looked up ahead of the edge so its tag
  // and length field reach the tracker on the same edge the word is
  // registered onto data_out.
  assign rd_word = mem[rd_ptr_reg[AW-1:0]];

  // Storage is not reset; it is only ever observed through an accepted read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg[AW-1:0]] <= {sop, data_in};
    end
  end

  // Pointers wrap naturally modulo 2*DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (soft_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + PW'(1);
    end
  end

  // Output register: zeroed on every cycle without an accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      sop_out_reg    <= 1'b0;
    end else if (soft_rst || !rd_en) begin
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      sop_out_reg    <= 1'b0;
    end else begin
      data_out_reg   <= rd_word[DATA_W-1:0];
      data_valid_reg <= 1'b1;
      sop_out_reg    <= rd_word[DATA_W];
    end
  end

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign sop_out    = sop_out_reg;

  router_pkt_len_tracker #(
    .DATA_W (DATA_W)
  ) u_len_tracker (
    .clk      (clk),
    .rst      (rst),
    .soft_rst (soft_rst),
    .rd_en    (rd_en),
    .rd_sop   (rd_word[DATA_W]),
    .rd_len   (rd_word[LEN_MSB:LEN_LSB]),
    .eop_out  (eop_out),
    .orphan   (orphan)
  );

`ifdef ROUTER_PKT_FIFO_LEVEL_EN
  localparam logic [PW-1:0] AF_LEVEL = PW'(AF_THRESH);

  logic [PW-1:0] level_reg;
  logic [PW-1:0] level_next;

  always_comb begin
    level_next = level_reg;
    if (wr_en && !rd_en) begin
      level_next = level_reg + PW'(1);
    end else if (rd_en && !wr_en) begin
      level_next = level_reg - PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_reg <= '0;
    end else if (soft_rst) begin
      level_reg <= '0;
    end else begin
      level_reg <= level_next;
    end
  end

  assign level       = level_reg;
  assign almost_full = (level_reg >= AF_LEVEL);
`endif

endmodule

// File: tb/tb_router_pkt_fifo.sv
// -----------------------------------------------------------------------------
// tb_router_pkt_fifo
// Directed stimulus with a scoreboard: each read the bench issues pushes its
// hand-computed expected word/flags into a queue; a monitor on the falling
// edge pops and compares whenever data_valid is high, and checks that idle
// cycles present all-zero outputs. Status signals are checked inline.
// -----------------------------------------------------------------------------
module tb_router_pkt_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              clk;
  logic              rst;
  logic              soft_rst;
  logic              we;
  logic              sop;
  logic [DATA_W-1:0] data_in;
  logic              re;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              sop_out;
  logic              eop_out;
  logic              orphan;
  logic              full;
  logic              empty;
`ifdef ROUTER_PKT_FIFO_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
  logic                   almost_full;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic              orph;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  router_pkt_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AF_THRESH (14)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .soft_rst   (soft_rst),
    .we         (we),
    .sop        (sop),
    .data_in    (data_in),
    .re         (re),
    .data_out   (data_out),
    .data_valid (data_valid),
    .sop_out    (sop_out),
    .eop_out    (eop_out),
    .orphan     (orphan),
    .full       (full),
    .empty      (empty)
`ifdef ROUTER_PKT_FIFO_LEVEL_EN
    ,
    .level       (level),
    .almost_full (almost_full)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (data_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_read: got data 0x%0h with no read outstanding", data_out);
        end else begin
          e = exp_q.pop_front();
          $display("READ  data=0x%02h sop=%0b eop=%0b orphan=%0b", data_out, sop_out, eop_out, orphan);
          check("rd_data",   32'(data_out), 32'(e.data));
          check("rd_sop",    32'(sop_out),  32'(e.sop));
          check("rd_eop",    32'(eop_out),  32'(e.eop));
          check("rd_orphan", 32'(orphan),   32'(e.orph));
        end
      end else begin
        check("idle_outputs_zero", {21'd0, data_valid, data_out, sop_out, eop_out, orphan}, 32'd0);
      end
    end
  end

  // One clock of stimulus; inputs change 1 time unit after the rising edge.
  task automatic cyc(input logic w, input logic s, input logic [DATA_W-1:0] d,
                     input logic r, input logic f);
    we = w; sop = s; data_in = d; re = r; soft_rst = f;
    @(posedge clk);
    #1;
    we = 1'b0; sop = 1'b0; data_in = '0; re = 1'b0; soft_rst = 1'b0;
  endtask

  task automatic wr(input logic s, input logic [DATA_W-1:0] d);
    $display("WRITE data=0x%02h sop=%0b full=%0b", d, s, full);
    cyc(1'b1, s, d, 1'b0, 1'b0);
  endtask

  task automatic push_exp(input logic [DATA_W-1:0] d, input logic s, input logic e, input logic o);
    exp_t x;
    x.data = d; x.sop = s; x.eop = e; x.orph = o;
    exp_q.push_back(x);
  endtask

  task automatic rd(input logic [DATA_W-1:0] d, input logic s, input logic e, input logic o);
    push_exp(d, s, e, o);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; soft_rst = 1'b0; we = 1'b0; sop = 1'b0; re = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_full",  32'(full),  32'd0);
    check("reset_valid", 32'(data_valid), 32'd0);
`ifdef ROUTER_PKT_FIFO_LEVEL_EN
    check("reset_level", 32'(level), 32'd0);
`endif
    rst = 1'b0;

    // Fill to full, drop a write, drain in order (no header read yet: orphans).
    for (int i = 1; i <= 16; i++) begin
      wr(1'b0, 8'(i));
      if (i == 1)  check("first_write_accepted", 32'(empty), 32'd0);
      if (i == 15) check("not_full_at_15", 32'(full), 32'd0);
    end
    check("full_at_16", 32'(full), 32'd1);
    wr(1'b0, 8'hFF);
    check("full_after_drop", 32'(full), 32'd1);
    for (int i = 1; i <= 16; i++) rd(8'(i), 1'b0, 1'b0, 1'b1);
    check("empty_after_drain", 32'(empty), 32'd1);

    // Framed packet: header length 3 -> 3 payload + parity.
    wr(1'b1, 8'h0C);
    wr(1'b0, 8'hA1);
    wr(1'b0, 8'hA2);
    wr(1'b0, 8'hA3);
    wr(1'b0, 8'h5E);
    rd(8'h0C, 1'b1, 1'b0, 1'b0);
    rd(8'hA1, 1'b0, 1'b0, 1'b0);
    rd(8'hA2, 1'b0, 1'b0, 1'b0);
    rd(8'hA3, 1'b0, 1'b0, 1'b0);
    rd(8'h5E, 1'b0, 1'b1, 1'b0);

    // Zero-length header, truncated packet, then a stray word.
    wr(1'b1, 8'h00);
    wr(1'b0, 8'h99);
    wr(1'b1, 8'h0C);
    wr(1'b0, 8'hA1);
    wr(1'b1, 8'h04);
    wr(1'b0, 8'hB1);
    wr(1'b0, 8'hB2);
    wr(1'b0, 8'hC3);
    rd(8'h00, 1'b1, 1'b0, 1'b0);
    rd(8'h99, 1'b0, 1'b1, 1'b0);
    rd(8'h0C, 1'b1, 1'b0, 1'b0);
    rd(8'hA1, 1'b0, 1'b0, 1'b0);
    rd(8'h04, 1'b1, 1'b0, 1'b0);
    rd(8'hB1, 1'b0, 1'b0, 1'b0);
    rd(8'hB2, 1'b0, 1'b1, 1'b0);
    rd(8'hC3, 1'b0, 1'b0, 1'b1);
    check("empty_after_frames", 32'(empty), 32'd1);

    // Simultaneous write and read while full: only the read is taken.
    for (int i = 0; i < 16; i++) wr(1'b0, 8'(8'h40 + i));
    check("full_before_simul", 32'(full), 32'd1);
    push_exp(8'h40, 1'b0, 1'b0, 1'b1);
    $display("WRITE+READ data=0x77 at full");
    cyc(1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
    check("not_full_after_simul", 32'(full), 32'd0);
    for (int i = 1; i < 16; i++) rd(8'(8'h40 + i), 1'b0, 1'b0, 1'b1);
    check("empty_0x77_not_stored", 32'(empty), 32'd1);

    // Simultaneous write and read while empty: only the write is taken.
    $display("WRITE+READ data=0x33 at empty");
    cyc(1'b1, 1'b0, 8'h33, 1'b1, 1'b0);
    check("simul_empty_no_valid", 32'(data_valid), 32'd0);
    check("simul_empty_write_taken", 32'(empty), 32'd0);
    rd(8'h33, 1'b0, 1'b0, 1'b1);
    check("empty_after_0x33", 32'(empty), 32'd1);

    // Flush mid-packet; flush beats a concurrent read and write.
    wr(1'b1, 8'h0C);
    wr(1'b0, 8'hA1);
    wr(1'b0, 8'hA2);
    wr(1'b0, 8'hA3);
    wr(1'b0, 8'h5E);
    rd(8'h0C, 1'b1, 1'b0, 1'b0);
    rd(8'hA1, 1'b0, 1'b0, 1'b0);
    $display("SOFT_RST with we=1 re=1");
    cyc(1'b1, 1'b0, 8'hEE, 1'b1, 1'b1);
    check("soft_rst_empty", 32'(empty), 32'd1);
    check("soft_rst_no_valid", 32'(data_valid), 32'd0);
    wr(1'b0, 8'h55);
    rd(8'h55, 1'b0, 1'b0, 1'b1);

    // Occupancy, then an asynchronous reset between edges.
    for (int i = 0; i < 14; i++) wr(1'b0, 8'(8'h60 + i));
`ifdef ROUTER_PKT_FIFO_LEVEL_EN
    check("level_14", 32'(level), 32'd14);
    check("almost_full_14", 32'(almost_full), 32'd1);
`endif
    rd(8'h60, 1'b0, 1'b0, 1'b1);
`ifdef ROUTER_PKT_FIFO_LEVEL_EN
    check("level_13", 32'(level), 32'd13);
    check("almost_full_13", 32'(almost_full), 32'd0);
`endif
    @(posedge clk);
    #3;
    $display("RST pulse between edges");
    rst = 1'b1;
    #1;
    check("async_rst_empty", 32'(empty), 32'd1);
    check("async_rst_full",  32'(full),  32'd0);
`ifdef ROUTER_PKT_FIFO_LEVEL_EN
    check("async_rst_level", 32'(level), 32'd0);
    check("async_rst_almost_full", 32'(almost_full), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr(1'b0, 8'hA5);
    check("write_after_rst", 32'(empty), 32'd0);
    rd(8'hA5, 1'b0, 1'b0, 1'b1);
    check("empty_end", 32'(empty), 32'd1);

    @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_pkt_fifo.md
ROUTER_PKT_FIFO -- requirements
Module: router_pkt_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, the payload word width in bits (minimum 4).
REQ-002 The block SHALL have parameter DEPTH, default 16, the number of storage entries (a power of 2, minimum 4).
REQ-003 The block SHALL have parameter AF_THRESH, default 14, the occupancy at or above which almost_full asserts.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port soft_rst, input, 1 bit: synchronous flush.
REQ-007 The block SHALL have port we, input, 1 bit: write request.
REQ-008 The block SHALL have port sop, input, 1 bit: marks the data_in word as a packet header.
REQ-009 The block SHALL have port data_in, input, DATA_W bits: write data.
REQ-010 The block SHALL have port re, input, 1 bit: read request.
REQ-011 The block SHALL have port data_out, output, DATA_W bits: registered read data.
REQ-012 The block SHALL have port data_valid, output, 1 bit: data_out holds a word read on the previous edge.
REQ-013 The block SHALL have ports sop_out and eop_out, outputs, 1 bit each: header and last-word flags, qualified by data_valid.
REQ-014 The block SHALL have port orphan, output, 1 bit: one-cycle pulse when a non-header word is read outside any packet.
REQ-015 The block SHALL have ports full and empty, outputs, 1 bit each: combinational status.

Function
REQ-016 The block SHALL store DEPTH entries of DATA_W+1 bits, consisting of the sop tag and the data.
REQ-017 The block SHALL use read and write pointers of log2(DEPTH)+1 bits; full SHALL be MSBs differing with lower bits equal, empty SHALL be pointers equal, and all DEPTH entries SHALL be usable.
REQ-018 The block SHALL accept a write only when we=1 and full=0; a write while full SHALL be dropped with no pointer or memory change.
REQ-019 The block SHALL accept a read only when re=1 and empty=0; on the next cycle it SHALL present data_out, data_valid=1 and sop_out=the stored tag.
REQ-020 When no read is accepted, the next cycle SHALL have data_valid=0 and data_out, sop_out, eop_out and orphan all 0; data_out SHALL never be high-impedance.
REQ-021 Full and empty status SHALL be evaluated from the pre-edge state: on simultaneous we/re while full, only the read is accepted; while empty, only the write is accepted; otherwise both are accepted and occupancy is unchanged.
REQ-022 Pointers SHALL wrap modulo 2*DEPTH with no special-case logic.
REQ-023 The block SHALL track the remaining packet length in a counter rem of DATA_W-1 bits.
REQ-024 On reading a tagged word, rem SHALL load {data[DATA_W-1:2]}+1, covering payload plus parity.
REQ-025 On reading an untagged word with rem>0, rem SHALL decrement by 1; when rem goes from 1 to 0, eop_out SHALL be 1 alongside that word's data_valid.
REQ-026 On reading an untagged word with rem=0, the word SHALL be delivered and orphan SHALL pulse with eop_out=0.
REQ-027 A header read while rem>0 SHALL reload rem, and no eop_out SHALL be issued for the truncated packet.
REQ-028 A header with length field 0 SHALL load rem=1, so the next untagged word carries eop_out.
REQ-029 soft_rst SHALL take priority over we/re and, on the edge where it is sampled, SHALL zero pointers, rem and all registered outputs; memory contents need not be cleared.

Reset
REQ-030 While rst=1, independent of clk, all pointers, rem and registered outputs SHALL be 0, so that full=0 and empty=1.
REQ-031 After rst deasserts, the first write SHALL be accepted on the first rising edge with we=1.
REQ-032 Memory contents SHALL be unspecified after rst and never observable, since reads are gated by empty.

Configuration
REQ-033 The macro ROUTER_PKT_FIFO_LEVEL_EN SHALL control level reporting.
REQ-034 With ROUTER_PKT_FIFO_LEVEL_EN defined, the block SHALL add output level (log2(DEPTH)+1 bits, the registered occupancy count, reset 0) and output almost_full (1 when level>=AF_THRESH, reset 0).
REQ-035 Without ROUTER_PKT_FIFO_LEVEL_EN, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-036 A shared package router_pkg SHALL hold the default constants (DATA_W, DEPTH, AF_THRESH) and the header length-field bit positions [DATA_W-1:2].
REQ-037 The block SHALL instantiate exactly one sub-module, router_pkt_len_tracker, which holds rem and generates eop_out and orphan.
REQ-038 Storage, pointers and status logic SHALL remain in router_pkt_fifo.

Verification
REQ-039 Scenario (defaults): 16 writes of 0x01..0x10 give full=1 after the 16th; a 17th write of 0xFF is dropped; 16 reads return 0x01..0x10 in order, then empty=1.
REQ-040 Scenario: write header 0x0C with sop=1, payload 0xA1,0xA2,0xA3 and parity 0x5E; reads give sop_out=1 on word 1 and eop_out=1 only on word 5 (0x5E).
REQ-041 Scenario: at full, assert we=1 (data 0x77) and re=1 in one cycle; the oldest word is read, 0x77 is not stored, and full=0 after the edge.
REQ-042 Scenario: at empty, assert we=1 (data 0x33) and re=1; the write is accepted, data_valid=0 next cycle, and one cycle later 0x33 is readable.
REQ-043 Scenario: soft_rst mid-packet after 2 of 5 words are read gives empty=1 and data_valid=0 next cycle; a later untagged read pulses orphan=1.
REQ-044 Scenario (ROUTER_PKT_FIFO_LEVEL_EN defined): 14 writes give level=14 and almost_full=1; one read gives level=13 and almost_full=0; an rst pulse between edges zeroes level immediately.
